// File: rtl/ga_input_feeder.sv
// rtl/ga_input_feeder.sv - sample FIFO and pulse sequencer feeding ga_top, with result monitor.
// Optional GA_FEEDER_STATS_EN adds a saturating stall_cntr output.
module ga_input_feeder #(
  parameter int DATA_W     = 6,
  parameter int M_MAX      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLDOFF    = 4,
  parameter int CNT_W      = 32
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_W-1:0]                 s_v_vec [0:M_MAX-1],
  input  logic [DATA_W-1:0]                 s_d,
  input  logic                              cfg_replay_en,
  input  logic                              ga_ready,
  output logic                              o_valid_pls,
  output logic [DATA_W-1:0]                 o_v_vec [0:M_MAX-1],
  output logic [DATA_W-1:0]                 o_d,
  input  logic                              ga_valid_lvl,
  input  logic [DATA_W-1:0]                 ga_y,
  output logic [DATA_W-1:0]                 res_y,
  output logic [CNT_W-1:0]                  sent_cntr,
  output logic [CNT_W-1:0]                  result_cntr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
`ifdef GA_FEEDER_STATS_EN
  ,
  output logic [CNT_W-1:0]                  stall_cntr
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int HC_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF+1) : 1;
  localparam logic [HC_W-1:0]  HC_MAX   = HC_W'(HOLDOFF);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DROP = 2'd1,
    WAIT_RDY  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem_v [0:FIFO_DEPTH-1][0:M_MAX-1];
  logic [DATA_W-1:0] mem_d [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count, count_n;
  logic              full_q, ne_q;
  logic              has_last;
  logic [HC_W-1:0]   hc, hc_n;
  logic              launch, use_fifo;
  logic              push, pop;
  logic              vl_q;

  assign s_ready    = !full_q;
  assign push       = s_valid && !full_q;
  assign pop        = launch && use_fifo;
  assign fifo_level = count;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_v[wr_ptr] <= s_v_vec;
      mem_d[wr_ptr] <= s_d;
    end
  end

  // ne_q deliberately lags count by one edge: it sets the push-to-pulse latency
  // and is never stale-high in IDLE, since pops only happen when leaving IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ne_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_n;
      full_q <= (count_n == LVL_FULL);
      ne_q   <= (count != '0);
    end
  end

  always_comb begin
    state_n  = state;
    hc_n     = hc;
    launch   = 1'b0;
    use_fifo = 1'b0;
    case (state)
      IDLE: begin
        if (ga_ready && (ne_q || (cfg_replay_en && has_last))) begin
          launch   = 1'b1;
          use_fifo = ne_q;
          hc_n     = '0;
          state_n  = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!ga_ready)         state_n = WAIT_RDY;
        else if (hc == HC_MAX) state_n = IDLE;
        else                   hc_n    = hc + 1'b1;
      end
      WAIT_RDY: begin
        if (ga_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Replay needs no shadow copy: o_v_vec/o_d already hold the last issued sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      hc          <= '0;
      has_last    <= 1'b0;
      o_valid_pls <= 1'b0;
      o_d         <= '0;
      sent_cntr   <= '0;
      for (int i = 0; i < M_MAX; i++) o_v_vec[i] <= '0;
    end else begin
      state       <= state_n;
      hc          <= hc_n;
      o_valid_pls <= launch;
      if (launch) begin
        has_last  <= 1'b1;
        sent_cntr <= sent_cntr + 1'b1;
        if (use_fifo) begin
          o_v_vec <= mem_v[rd_ptr];
          o_d     <= mem_d[rd_ptr];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vl_q        <= 1'b0;
      res_y       <= '0;
      result_cntr <= '0;
    end else begin
      vl_q <= ga_valid_lvl;
      if (ga_valid_lvl && !vl_q) begin
        res_y       <= ga_y;
        result_cntr <= result_cntr + 1'b1;
      end
    end
  end

`ifdef GA_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cntr <= '0;
    end else if ((count != '0) && !ga_ready && (stall_cntr != '1)) begin
      stall_cntr <= stall_cntr + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ga_input_feeder.sv
// tb/tb_ga_input_feeder.sv - directed bench for ga_input_feeder with a pulse scoreboard.
module tb_ga_input_feeder;
  localparam int DATA_W     = 6;
  localparam int M_MAX      = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int HOLDOFF    = 4;
  localparam int CNT_W      = 32;
  localparam int VW         = DATA_W*M_MAX;
  localparam int LVL_W      = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [VW-1:0]     v;
  } samp_t;

  logic              clk, rstn, s_valid, s_ready, cfg_replay_en, ga_ready;
  logic [DATA_W-1:0] s_v_vec [0:M_MAX-1];
  logic [DATA_W-1:0] o_v_vec [0:M_MAX-1];
  logic [DATA_W-1:0] s_d, o_d, ga_y, res_y;
  logic              o_valid_pls, ga_valid_lvl;
  logic [CNT_W-1:0]  sent_cntr, result_cntr;
  logic [LVL_W-1:0]  fifo_level;
`ifdef GA_FEEDER_STATS_EN
  logic [CNT_W-1:0]  stall_cntr;
`endif

  logic ga_man, ga_model, model_en, expect_replay;
  assign ga_ready = model_en ? ga_model : ga_man;

  int    checks = 0, failures = 0, pulse_cnt = 0, cyc_n = 0;
  int    mlow = 0;
  bit    mpend = 0;
  samp_t sb [$];
  samp_t last_exp;
  int    pt [$];

  ga_input_feeder #(
    .DATA_W(DATA_W), .M_MAX(M_MAX), .FIFO_DEPTH(FIFO_DEPTH),
    .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_v_vec(s_v_vec), .s_d(s_d), .cfg_replay_en(cfg_replay_en),
    .ga_ready(ga_ready), .o_valid_pls(o_valid_pls), .o_v_vec(o_v_vec),
    .o_d(o_d), .ga_valid_lvl(ga_valid_lvl), .ga_y(ga_y), .res_y(res_y),
    .sent_cntr(sent_cntr), .result_cntr(result_cntr), .fifo_level(fifo_level)
`ifdef GA_FEEDER_STATS_EN
    , .stall_cntr(stall_cntr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] pack_v(input logic [DATA_W-1:0] a [0:M_MAX-1]);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < M_MAX; i++) r[i*DATA_W +: DATA_W] = a[i];
    return r;
  endfunction

  function automatic logic [VW-1:0] mkv(input int base);
    logic [VW-1:0] r;
    for (int i = 0; i < M_MAX; i++) r[i*DATA_W +: DATA_W] = DATA_W'(base + 3*i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score pulses, advance the ga_ready model.
  task automatic cyc();
    samp_t e;
    @(negedge clk);
    cyc_n++;
    if (o_valid_pls === 1'b1) begin
      pulse_cnt++;
      pt.push_back(cyc_n);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        last_exp = e;
        chk("pulse_d", o_d, e.d);
        chk("pulse_v", pack_v(o_v_vec), e.v);
      end else if (expect_replay) begin
        chk("replay_d", o_d, last_exp.d);
        chk("replay_v", pack_v(o_v_vec), last_exp.v);
      end else begin
        chk("unexpected_pulse", o_valid_pls, 1'b0);
      end
      if (model_en) mpend = 1;
    end else if (mpend) begin
      ga_model = 1'b0;
      mlow = 5;
      mpend = 0;
    end else if (mlow > 0) begin
      mlow--;
      if (mlow == 0) ga_model = 1'b1;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [VW-1:0] v);
    bit ok;
    ok = 0;
    for (int i = 0; i < M_MAX; i++) s_v_vec[i] = v[i*DATA_W +: DATA_W];
    s_d = d;
    s_valid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (s_ready) begin
        sb.push_back('{d: d, v: v});
        ok = 1;
      end
      cyc();
    end
    s_valid = 1'b0;
    if (!ok) chk("push_timeout", s_ready, 1'b1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) cyc();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int p, s, g1, g2;
    logic [VW-1:0] v12;
    rstn = 1'b0; s_valid = 1'b0; s_d = '0; cfg_replay_en = 1'b0;
    ga_man = 1'b1; ga_model = 1'b1; model_en = 1'b0; expect_replay = 1'b0;
    ga_valid_lvl = 1'b0; ga_y = '0;
    for (int i = 0; i < M_MAX; i++) s_v_vec[i] = '0;

    // Reset state
    repeat (3) cyc();
    chk("rst_valid", o_valid_pls, 1'b0);
    chk("rst_o_d", o_d, 0);
    chk("rst_o_v", pack_v(o_v_vec), 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_sent", sent_cntr, 0);
    chk("rst_result", result_cntr, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_s_ready", s_ready, 1'b1);
    rstn = 1'b1;
    p = pulse_cnt;
    repeat (20) cyc();
    chk("idle_no_pulse", pulse_cnt - p, 0);
    chk("idle_s_ready", s_ready, 1'b1);
    chk("idle_level", fifo_level, 0);

    // Single sample, latency and handshake model
    model_en = 1'b1;
    v12 = '0;
    for (int i = 0; i < 7; i++) v12[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    p = pulse_cnt;
    push(6'd28, v12);
    cyc();
    chk("lat_edge1", o_valid_pls, 1'b0);
    cyc();
    chk("lat_edge2", o_valid_pls, 1'b1);
    repeat (15) cyc();
    chk("single_pulses", pulse_cnt - p, 1);
    chk("single_sent", sent_cntr, 1);
    chk("single_o_d_hold", o_d, 28);

    // Fill to full with ga_ready low, then drain in order
    model_en = 1'b0; ga_man = 1'b0;
    cyc();
    for (int i = 0; i < FIFO_DEPTH; i++) push(DATA_W'(i + 1), mkv(5*i));
    chk("full_level", fifo_level, FIFO_DEPTH);
    chk("full_s_ready", s_ready, 1'b0);
    repeat (2) cyc();
    chk("full_hold_s_ready", s_ready, 1'b0);
    mpend = 0; mlow = 0; ga_model = 1'b1; model_en = 1'b1;
    p = pulse_cnt;
    push(6'd9, mkv(40));
    chk("ninth_after_first_pop", pulse_cnt - p, 1);
    chk("ninth_level", fifo_level, FIFO_DEPTH);
    drain(300);
    repeat (15) cyc();
    chk("fill_sent", sent_cntr, pulse_cnt);
    chk("fill_level_empty", fifo_level, 0);

    // Replay of the last sample while starved
    push(6'd5, mkv(100));
    drain(60);
    repeat (15) cyc();
    expect_replay = 1'b1;
    cfg_replay_en = 1'b1;
    p = pulse_cnt; s = sent_cntr;
    repeat (60) cyc();
    chk("replay_count_ge3", (pulse_cnt - p) >= 3, 1'b1);
    chk("replay_sent", sent_cntr - s, pulse_cnt - p);
    cfg_replay_en = 1'b0;
    repeat (15) cyc();
    expect_replay = 1'b0;
    p = pulse_cnt;
    repeat (30) cyc();
    chk("replay_stopped", pulse_cnt - p, 0);

    // ga_ready stuck high: fixed pulse spacing
    model_en = 1'b0; ga_man = 1'b1;
    pt.delete();
    push(6'd11, mkv(7));
    push(6'd12, mkv(8));
    push(6'd13, mkv(9));
    drain(60);
    g1 = (pt.size() >= 3) ? pt[1] - pt[0] : -1;
    g2 = (pt.size() >= 3) ? pt[2] - pt[1] : -1;
    chk("stuck_pulses", pt.size(), 3);
    chk("stuck_gap1", g1, HOLDOFF + 2);
    chk("stuck_gap2", g2, HOLDOFF + 2);
    repeat (10) cyc();
    chk("stuck_sent", sent_cntr, pulse_cnt);

    // Result monitor
    ga_y = 6'd17; ga_valid_lvl = 1'b1;
    repeat (5) cyc();
    ga_y = 6'd9;
    repeat (5) cyc();
    chk("mon_count1", result_cntr, 1);
    chk("mon_res_y1", res_y, 17);
    ga_valid_lvl = 1'b0;
    repeat (3) cyc();
    ga_y = 6'd3; ga_valid_lvl = 1'b1;
    repeat (3) cyc();
    chk("mon_count2", result_cntr, 2);
    chk("mon_res_y2", res_y, 3);
    ga_valid_lvl = 1'b0;

    // Reset with samples buffered
    ga_man = 1'b0;
    repeat (12) cyc();
    push(6'd21, mkv(1));
    push(6'd22, mkv(2));
    push(6'd23, mkv(3));
    chk("mid_level", fifo_level, 3);
    rstn = 1'b0;
    cyc();
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_sent", sent_cntr, 0);
    chk("mid_rst_result", result_cntr, 0);
    chk("mid_rst_res_y", res_y, 0);
    chk("mid_rst_o_d", o_d, 0);
    chk("mid_rst_o_v", pack_v(o_v_vec), 0);
    chk("mid_rst_valid", o_valid_pls, 1'b0);
    sb.delete();
    rstn = 1'b1;
    ga_man = 1'b1; cfg_replay_en = 1'b1;
    p = pulse_cnt;
    repeat (20) cyc();
    chk("post_rst_no_replay", pulse_cnt - p, 0);
    cfg_replay_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
